set_mode_sched: RTL and testbench

// - Time/alarm setting scheduler. Sits between the key debouncer and the clock-control datapath.
// - Sequences the edit field on each MODE press: RUN -> HOUR -> MIN -> SEC -> AL_HOUR -> AL_MIN -> RUN.
// - Turns INC presses and held INC into one-cycle increment strobes, with auto-repeat.
// - Freezes timekeeping while time fields are edited and drives the display blink phase.
// - Returns to RUN after an inactivity timeout.

---
 rtl/set_mode_sched.sv | 174 +++++++++++++++++
 tb/tb_set_mode_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_mode_sched.sv
// Time/alarm setting scheduler: MODE-driven edit-field sequencer, INC strobes with auto-repeat,
// inactivity timeout and blink phase. Define ALARM_FIELDS_EN to add the AL_HOUR/AL_MIN fields.
module set_mode_sched #(
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_MS      = 10000,
  parameter int BLINK_HALF_MS   = 250
) (
  input  logic       XTAL_OSC,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  input  logic       inc_level,
  output logic [2:0] field,
  output logic       run_en,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       inc_al_hour,
  output logic       inc_al_min,
  output logic       blink_on
);

  localparam logic [2:0] F_RUN     = 3'd0;
  localparam logic [2:0] F_HOUR    = 3'd1;
  localparam logic [2:0] F_MIN     = 3'd2;
  localparam logic [2:0] F_SEC     = 3'd3;
  localparam logic [2:0] F_AL_HOUR = 3'd4;
  localparam logic [2:0] F_AL_MIN  = 3'd5;

  localparam int REP_W   = $clog2(REPEAT_DELAY_MS + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_MS + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_MS + 1);

  localparam logic [REP_W-1:0]   REP_SAT    = REP_W'(REPEAT_DELAY_MS);
  localparam logic [REP_W-1:0]   REP_LAST   = REP_W'(REPEAT_DELAY_MS - 1);
  // Reloading to DELAY-RATE after a repeat makes the next strobe land REPEAT_RATE_MS ticks later.
  localparam logic [REP_W-1:0]   REP_RELOAD = REP_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_MS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_MS - 1);

  logic               armed, armed_n;
  logic [REP_W-1:0]   rep_cnt, rep_n;
  logic [IDLE_W-1:0]  idle_cnt, idle_n;
  logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
  logic [2:0]         field_n;
  logic               blink_n;
  logic               strobe;

  function automatic logic [2:0] next_field(input logic [2:0] f);
    case (f)
      F_RUN:     next_field = F_HOUR;
      F_HOUR:    next_field = F_MIN;
      F_MIN:     next_field = F_SEC;
`ifdef ALARM_FIELDS_EN
      F_SEC:     next_field = F_AL_HOUR;
      F_AL_HOUR: next_field = F_AL_MIN;
`endif
      default:   next_field = F_RUN;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    field_n     = field;
    armed_n     = armed;
    rep_n       = rep_cnt;
    idle_n      = idle_cnt;
    blink_cnt_n = blink_cnt;
    blink_n     = blink_on;
    strobe      = 1'b0;

    if (mode_pulse) begin
      field_n     = next_field(field);
      armed_n     = 1'b0;
      rep_n       = '0;
      idle_n      = '0;
      blink_cnt_n = '0;
      blink_n     = 1'b1;
    end else if (field == F_RUN) begin
      armed_n     = 1'b0;
      rep_n       = '0;
      idle_n      = '0;
      blink_cnt_n = '0;
      blink_n     = 1'b1;
    end else if (inc_pulse) begin
      strobe      = 1'b1;
      armed_n     = 1'b1;
      rep_n       = '0;
      idle_n      = '0;
      blink_cnt_n = '0;
      blink_n     = 1'b1;
    end else begin
      if (armed && !inc_level) begin
        armed_n = 1'b0;
        rep_n   = '0;
      end else if (armed && tick_1ms) begin
        if (rep_cnt == REP_LAST && field != F_SEC) begin
          strobe = 1'b1;
          rep_n  = REP_RELOAD;
        end else if (rep_cnt != REP_SAT) begin
          rep_n = rep_cnt + 1'b1;
        end
      end

      if (strobe) begin
        idle_n      = '0;
        blink_cnt_n = '0;
        blink_n     = 1'b1;
      end else if (tick_1ms) begin
        if (idle_cnt >= IDLE_LAST) begin
          field_n     = F_RUN;
          armed_n     = 1'b0;
          rep_n       = '0;
          idle_n      = '0;
          blink_cnt_n = '0;
          blink_n     = 1'b1;
        end else begin
          idle_n = idle_cnt + 1'b1;
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n = '0;
            blink_n     = ~blink_on;
          end else begin
            blink_cnt_n = blink_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge XTAL_OSC or negedge rst) begin
    if (!rst) begin
      field     <= F_RUN;
      run_en    <= 1'b1;
      inc_hour  <= 1'b0;
      inc_min   <= 1'b0;
      clr_sec   <= 1'b0;
      blink_on  <= 1'b1;
      armed     <= 1'b0;
      rep_cnt   <= '0;
      idle_cnt  <= '0;
      blink_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      field     <= field_n;
      run_en    <= (field_n == F_RUN) || (field_n == F_AL_HOUR) || (field_n == F_AL_MIN);
      inc_hour  <= strobe && (field == F_HOUR);
      inc_min   <= strobe && (field == F_MIN);
      clr_sec   <= strobe && (field == F_SEC);
      blink_on  <= blink_n;
      armed     <= armed_n;
      rep_cnt   <= rep_n;
      idle_cnt  <= idle_n;
      blink_cnt <= blink_cnt_n;
    end
  end

`ifdef ALARM_FIELDS_EN
  always_ff @(posedge XTAL_OSC or negedge rst) begin
    if (!rst) begin
      inc_al_hour <= 1'b0;
      inc_al_min  <= 1'b0;
    end else begin
      inc_al_hour <= strobe && (field == F_AL_HOUR);
      inc_al_min  <= strobe && (field == F_AL_MIN);
    end
  end
`else
  assign inc_al_hour = 1'b0;
  assign inc_al_min  = 1'b0;
`endif

endmodule

// File: tb/tb_set_mode_sched.sv
// Directed bench for set_mode_sched; inputs change and outputs are observed on the falling edge.
module tb_set_mode_sched;

  logic       clk;
  logic       rst;
  logic       tick_1ms, mode_pulse, inc_pulse, inc_level;
  logic [2:0] field;
  logic       run_en, inc_hour, inc_min, clr_sec, inc_al_hour, inc_al_min, blink_on;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_idx = 0;
  int n_hour, n_min, n_sec, n_alh, n_alm;
  int hour_at [8];

  set_mode_sched dut (
    .XTAL_OSC    (clk),
    .rst         (rst),
    .tick_1ms    (tick_1ms),
    .mode_pulse  (mode_pulse),
    .inc_pulse   (inc_pulse),
    .inc_level   (inc_level),
    .field       (field),
    .run_en      (run_en),
    .inc_hour    (inc_hour),
    .inc_min     (inc_min),
    .clr_sec     (clr_sec),
    .inc_al_hour (inc_al_hour),
    .inc_al_min  (inc_al_min),
    .blink_on    (blink_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_counts();
    n_hour = 0; n_min = 0; n_sec = 0; n_alh = 0; n_alm = 0;
    tick_idx = 0;
    foreach (hour_at[i]) hour_at[i] = -1;
  endtask

  // One clock: apply inputs, let the rising edge take them, observe on the falling edge.
  task automatic step(input logic t, input logic m, input logic p);
    tick_1ms = t; mode_pulse = m; inc_pulse = p;
    @(negedge clk);
    if (t) tick_idx++;
    if (inc_hour === 1'b1) begin
      if (n_hour < 8) hour_at[n_hour] = tick_idx;
      n_hour++;
    end
    if (inc_min === 1'b1) n_min++;
    if (clr_sec === 1'b1) n_sec++;
    if (inc_al_hour === 1'b1) n_alh++;
    if (inc_al_min === 1'b1) n_alm++;
    tick_1ms = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic goto_field(input logic [2:0] f);
    for (int i = 0; i < 8 && field !== f; i++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (field !== f) begin
      n_fail++;
      $display("FAIL goto_field: field=%0d expected %0d", field, f);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (field !== 3'd0 || run_en !== 1'b1 || blink_on !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: field=%0d run_en=%b blink_on=%b expected 0 1 1", field, run_en, blink_on);
    end
    n_checks++;
    if ({inc_hour, inc_min, clr_sec, inc_al_hour, inc_al_min} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {inc_hour, inc_min, clr_sec, inc_al_hour, inc_al_min});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mode_seq();
    logic [2:0] exp_f;
    logic       exp_run;
    clear_counts();
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      exp_f = 3'(i);
      n_checks++;
      if (field !== exp_f || run_en !== 1'b0) begin
        n_fail++;
        $display("FAIL mode_seq_%0d: field=%0d run_en=%b expected %0d 0", i, field, run_en, exp_f);
      end
    end
`ifdef ALARM_FIELDS_EN
    for (int i = 4; i <= 6; i++) begin
      step(1'b0, 1'b1, 1'b0);
      exp_f = (i == 6) ? 3'd0 : 3'(i);
      exp_run = 1'b1;
      n_checks++;
      if (field !== exp_f || run_en !== exp_run) begin
        n_fail++;
        $display("FAIL mode_seq_%0d: field=%0d run_en=%b expected %0d 1", i, field, run_en, exp_f);
      end
    end
    goto_field(3'd4);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (n_alh !== 1 || n_hour !== 0) begin
      n_fail++;
      $display("FAIL al_hour_strobe: al_hour=%0d hour=%0d expected 1 0", n_alh, n_hour);
    end
    goto_field(3'd0);
`else
    step(1'b0, 1'b1, 1'b0);
    exp_f = 3'd0;
    exp_run = 1'b1;
    n_checks++;
    if (field !== exp_f || run_en !== exp_run) begin
      n_fail++;
      $display("FAIL mode_seq_wrap: field=%0d run_en=%b expected 0 1", field, run_en);
    end
`endif
  endtask

  task automatic test_hour_repeat();
    int exp_at [7] = '{0, 500, 600, 700, 800, 900, 1000};
    goto_field(3'd1);
    clear_counts();
    inc_level = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    ticks(1000);
    inc_level = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    ticks(600);
    n_checks++;
    if (n_hour !== 7) begin
      n_fail++;
      $display("FAIL repeat_count: inc_hour strobes=%0d expected 7", n_hour);
    end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (hour_at[i] !== exp_at[i]) begin
        n_fail++;
        $display("FAIL repeat_tick_%0d: strobe at tick %0d expected %0d", i, hour_at[i], exp_at[i]);
      end
    end
    n_checks++;
    if (n_min + n_sec + n_alh + n_alm !== 0) begin
      n_fail++;
      $display("FAIL repeat_other_strobes: got %0d expected 0", n_min + n_sec + n_alh + n_alm);
    end
    goto_field(3'd0);
  endtask

  task automatic test_sec_and_run();
    goto_field(3'd3);
    clear_counts();
    inc_level = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    ticks(2000);
    inc_level = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (n_sec !== 1) begin
      n_fail++;
      $display("FAIL sec_no_repeat: clr_sec strobes=%0d expected 1", n_sec);
    end
    goto_field(3'd0);
    clear_counts();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (n_hour + n_min + n_sec + n_alh + n_alm !== 0 || field !== 3'd0) begin
      n_fail++;
      $display("FAIL run_inc_ignored: strobes=%0d field=%0d expected 0 0",
               n_hour + n_min + n_sec + n_alh + n_alm, field);
    end
  endtask

  task automatic test_timeout();
    goto_field(3'd2);
    ticks(9999);
    n_checks++;
    if (field !== 3'd2) begin
      n_fail++;
      $display("FAIL timeout_early: field=%0d expected 2", field);
    end
    ticks(1);
    n_checks++;
    if (field !== 3'd0 || run_en !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_return: field=%0d run_en=%b expected 0 1", field, run_en);
    end
    goto_field(3'd2);
    ticks(9998);
    step(1'b1, 1'b0, 1'b1);
    ticks(9999);
    n_checks++;
    if (field !== 3'd2) begin
      n_fail++;
      $display("FAIL timeout_restart: field=%0d expected 2", field);
    end
    ticks(1);
    n_checks++;
    if (field !== 3'd0) begin
      n_fail++;
      $display("FAIL timeout_after_restart: field=%0d expected 0", field);
    end
  endtask

  task automatic test_mode_inc_same();
    goto_field(3'd1);
    clear_counts();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (field !== 3'd2 || n_hour !== 0 || n_min !== 0 || blink_on !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_beats_inc: field=%0d hour=%0d min=%0d blink=%b expected 2 0 0 1",
               field, n_hour, n_min, blink_on);
    end
    ticks(249);
    n_checks++;
    if (blink_on !== 1'b1) begin
      n_fail++;
      $display("FAIL blink_249: blink_on=%b expected 1", blink_on);
    end
    ticks(1);
    n_checks++;
    if (blink_on !== 1'b0) begin
      n_fail++;
      $display("FAIL blink_250: blink_on=%b expected 0", blink_on);
    end
    ticks(249);
    n_checks++;
    if (blink_on !== 1'b0) begin
      n_fail++;
      $display("FAIL blink_499: blink_on=%b expected 0", blink_on);
    end
    ticks(1);
    n_checks++;
    if (blink_on !== 1'b1) begin
      n_fail++;
      $display("FAIL blink_500: blink_on=%b expected 1", blink_on);
    end
    goto_field(3'd0);
  endtask

  task automatic test_reset_mid_repeat();
    goto_field(3'd1);
    inc_level = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    ticks(500);
    n_checks++;
    if (inc_hour !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_repeat_active: inc_hour=%b expected 1", inc_hour);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (field !== 3'd0 || inc_hour !== 1'b0 || blink_on !== 1'b1 || run_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_repeat: field=%0d inc_hour=%b blink=%b run_en=%b expected 0 0 1 1",
               field, inc_hour, blink_on, run_en);
    end
    @(negedge clk);
    rst = 1'b1;
    inc_level = 1'b0;
  endtask

  initial begin
    tick_1ms = 1'b0; mode_pulse = 1'b0; inc_pulse = 1'b0; inc_level = 1'b0;
    clear_counts();
    test_reset();
    test_mode_seq();
    test_hour_repeat();
    test_sec_and_run();
    test_timeout();
    test_mode_inc_same();
    test_reset_mid_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
